// File: rtl/timer_reload_ctrl.sv
// Programmable interval timer: reload/prescale/control registers, a
// prescaled down-counter with terminal-count reload and a latched interrupt.
module timer_reload_ctrl #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic             CLK,
    input  logic             RSTL,
    input  logic             WR,
    input  logic             RD,
    input  logic [1:0]       ADDR,
    input  logic [7:0]       DIN,
    output logic [7:0]       DOUT,
    output logic [WIDTH-1:0] CNT,
    output logic             TC,
    output logic             INT,
    input  logic             IACK
);

    logic [WIDTH-1:0]      reload;
    logic [WIDTH-1:0]      counter;
    logic [PRESCALE_W-1:0] ps_reg;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  run;
    logic                  oneshot;
    logic                  ien;
    logic [7:0]            snapshot;
    logic [7:0]            rd_data;

    logic wr_lo;
    logic wr_hi;
    logic wr_ps;
    logic wr_ctl;
    logic tick;
    logic term;
    logic restart;

    always_comb begin
        wr_lo   = WR && (ADDR == 2'd0);
        wr_hi   = WR && (ADDR == 2'd1);
        wr_ps   = WR && (ADDR == 2'd2);
        wr_ctl  = WR && (ADDR == 2'd3);
        tick    = run && (prescaler == '0);
        // A high-byte load pre-empts the terminal count of the same cycle
        term    = tick && (counter == '0) && !wr_hi;
        restart = wr_ctl && DIN[0] && !run;
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            prescaler <= '0;
        end else if (wr_hi || restart) begin
            prescaler <= ps_reg;
        end else if (run) begin
            prescaler <= tick ? ps_reg : prescaler - PRESCALE_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            counter <= '0;
        end else if (wr_hi) begin
            counter <= {DIN, reload[7:0]};
        end else if (tick) begin
            counter <= (counter == '0) ? reload : counter - WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            reload <= '0;
            ps_reg <= '0;
        end else begin
            if (wr_lo) reload[7:0] <= DIN;
            if (wr_hi) reload[WIDTH-1:8] <= DIN;
            if (wr_ps) ps_reg <= DIN[PRESCALE_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            run     <= 1'b0;
            oneshot <= 1'b0;
            ien     <= 1'b0;
        end else if (wr_ctl) begin
            run     <= DIN[0];
            oneshot <= DIN[1];
            ien     <= DIN[2];
        end else if (term && oneshot) begin
            run <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            TC  <= 1'b0;
            INT <= 1'b0;
        end else begin
            TC <= term;
            if (term && ien) INT <= 1'b1;
            else if (IACK)   INT <= 1'b0;
        end
    end

    always_comb begin
        rd_data = '0;
        case (ADDR)
            2'd0:    rd_data = counter[7:0];
            2'd1:    rd_data = snapshot;
            2'd2:    rd_data = 8'(ps_reg);
            default: rd_data = {5'b0, ien, oneshot, run};
        endcase
    end

    // Low-byte read latches the high byte so a two-read sequence is tear-free
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            DOUT     <= '0;
            snapshot <= '0;
        end else if (RD) begin
            DOUT <= rd_data;
            if (ADDR == 2'd0) snapshot <= counter[WIDTH-1:8];
        end
    end

    assign CNT = counter;

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// Directed and random stimulus for timer_reload_ctrl against a
// cycle-level behavioural model of the timer.
module tb_timer_reload_ctrl;

    logic        CLK  = 1'b0;
    logic        RSTL = 1'b0;
    logic        WR   = 1'b0;
    logic        RD   = 1'b0;
    logic [1:0]  ADDR = 2'd0;
    logic [7:0]  DIN  = 8'd0;
    logic        IACK = 1'b0;
    logic [7:0]  DOUT;
    logic [15:0] CNT;
    logic        TC;
    logic        INT;

    int checks  = 0;
    int errors  = 0;
    int tc_seen = 0;

    bit [15:0] m_reload;
    bit [15:0] m_cnt;
    bit [7:0]  m_psreg;
    bit [7:0]  m_ps;
    bit [7:0]  m_snap;
    bit [7:0]  m_dout;
    bit        m_run;
    bit        m_os;
    bit        m_ien;
    bit        m_tc;
    bit        m_int;

    timer_reload_ctrl #(.WIDTH(16), .PRESCALE_W(8)) dut (
        .CLK  (CLK),
        .RSTL (RSTL),
        .WR   (WR),
        .RD   (RD),
        .ADDR (ADDR),
        .DIN  (DIN),
        .DOUT (DOUT),
        .CNT  (CNT),
        .TC   (TC),
        .INT  (INT),
        .IACK (IACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_reload = '0; m_cnt = '0; m_psreg = '0; m_ps = '0;
        m_snap = '0; m_dout = '0; m_run = 0; m_os = 0;
        m_ien = 0; m_tc = 0; m_int = 0;
    endtask

    // One clock of the timer: reads see old state, time advances,
    // then register writes override.
    task automatic model_clk(input bit wr, input bit rd,
                             input bit [1:0] a, input bit [7:0] d,
                             input bit ack);
        bit tick, load, term, old_run;
        tick    = m_run && (m_ps == 8'd0);
        load    = wr && (a == 2'd1);
        term    = tick && (m_cnt == 16'd0) && !load;
        old_run = m_run;
        if (rd) begin
            case (a)
                2'd0: begin m_dout = m_cnt[7:0]; m_snap = m_cnt[15:8]; end
                2'd1: m_dout = m_snap;
                2'd2: m_dout = m_psreg;
                default: m_dout = {5'b0, m_ien, m_os, m_run};
            endcase
        end
        m_tc = term;
        if (term && m_ien) m_int = 1;
        else if (ack)      m_int = 0;
        if (m_run) m_ps = tick ? m_psreg : m_ps - 8'd1;
        if (tick)  m_cnt = (m_cnt == 16'd0) ? m_reload : m_cnt - 16'd1;
        if (term && m_os) m_run = 0;
        if (wr) begin
            case (a)
                2'd0: m_reload[7:0] = d;
                2'd1: begin
                    m_reload[15:8] = d;
                    m_cnt = {d, m_reload[7:0]};
                    m_ps = m_psreg;
                end
                2'd2: m_psreg = d;
                default: begin
                    if (d[0] && !old_run) m_ps = m_psreg;
                    m_run = d[0]; m_os = d[1]; m_ien = d[2];
                end
            endcase
        end
    endtask

    task automatic cyc(input bit wr, input bit rd, input bit [1:0] a,
                       input bit [7:0] d, input bit ack);
        WR = wr; RD = rd; ADDR = a; DIN = d; IACK = ack;
        @(posedge CLK);
        model_clk(wr, rd, a, d, ack);
        #1;
        WR = 0; RD = 0; IACK = 0;
        if (TC === 1'b1) tc_seen++;
        chk("cnt",  CNT, m_cnt);
        chk("tc",   16'(TC), 16'(m_tc));
        chk("int",  16'(INT), 16'(m_int));
        chk("dout", 16'(DOUT), 16'(m_dout));
    endtask

    task automatic do_wr(input bit [1:0] a, input bit [7:0] d);
        cyc(1, 0, a, d, 0);
    endtask

    task automatic do_rd(input bit [1:0] a);
        cyc(0, 1, a, 8'd0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 2'd0, 8'd0, 0);
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cnt", CNT, 16'h0);
        chk("rst_tc", 16'(TC), 16'h0);
        chk("rst_int", 16'(INT), 16'h0);
        #2 RSTL = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_rd(2'(i));
            chk("rst_rd", 16'(DOUT), 16'h0);
        end

        // periodic, reload 3, prescale 0
        do_wr(2'd0, 8'h03); do_wr(2'd1, 8'h00);
        do_wr(2'd2, 8'h00); do_wr(2'd3, 8'h05);
        tc_seen = 0;
        repeat (16) idle();
        chk("period4", 16'(tc_seen), 16'd4);
        chk("int_set", 16'(INT), 16'h1);
        cyc(0, 0, 2'd0, 8'd0, 1);
        chk("int_ack", 16'(INT), 16'h0);

        // prescale 2, reload 1
        do_wr(2'd3, 8'h00); do_wr(2'd2, 8'h02);
        do_wr(2'd0, 8'h01); do_wr(2'd1, 8'h00);
        do_wr(2'd3, 8'h05);
        tc_seen = 0;
        repeat (30) idle();
        chk("period6", 16'(tc_seen), 16'd5);
        idle();
        do_wr(2'd3, 8'h00);
        tc_seen = 0;
        repeat (10) idle();
        chk("stop_tc", 16'(tc_seen), 16'd0);
        chk("stop_cnt", CNT, 16'h0001);

        // one-shot, reload 2
        do_wr(2'd2, 8'h00); do_wr(2'd0, 8'h02);
        do_wr(2'd1, 8'h00); do_wr(2'd3, 8'h03);
        tc_seen = 0;
        repeat (10) idle();
        chk("os_tc", 16'(tc_seen), 16'd1);
        chk("os_cnt", CNT, 16'h0002);
        do_rd(2'd3);
        chk("os_ctl", 16'(DOUT), 16'h0002);
        tc_seen = 0;
        repeat (20) idle();
        chk("os_quiet", 16'(tc_seen), 16'd0);

        // tear-free readback of 0x12FF across a tick
        do_wr(2'd3, 8'h00); do_wr(2'd2, 8'h00);
        do_wr(2'd0, 8'hFF); do_wr(2'd1, 8'h12);
        do_wr(2'd3, 8'h01);
        do_rd(2'd0);
        chk("rd_lo", 16'(DOUT), 16'h00FF);
        chk("rd_cnt", CNT, 16'h12FE);
        do_rd(2'd1);
        chk("rd_snap", 16'(DOUT), 16'h0012);

        // reload 0: terminal count every clock, IACK loses to set
        do_wr(2'd3, 8'h00); do_wr(2'd0, 8'h00);
        do_wr(2'd1, 8'h00); do_wr(2'd3, 8'h05);
        repeat (3) begin
            cyc(0, 0, 2'd0, 8'd0, 1);
            chk("ack_vs_set", 16'(INT), 16'h1);
        end

        // random traffic
        repeat (400) begin
            bit       w, r, k;
            bit [1:0] a;
            bit [7:0] d;
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == 2'd1) d = 8'($urandom_range(0, 1));
            if (a == 2'd2) d = 8'($urandom_range(0, 3));
            k = ($urandom_range(0, 5) == 0);
            cyc(w, r, a, d, k);
        end

        // async reset with CNT=1 and INT pending
        do_wr(2'd3, 8'h00); do_wr(2'd2, 8'h00);
        do_wr(2'd0, 8'h01); do_wr(2'd1, 8'h00);
        do_wr(2'd3, 8'h05);
        idle(); idle();
        chk("pre_rst_cnt", CNT, 16'h0001);
        chk("pre_rst_int", 16'(INT), 16'h1);
        #2 RSTL = 1'b0;
        #1;
        m_reset();
        chk("arst_cnt", CNT, 16'h0);
        chk("arst_int", 16'(INT), 16'h0);
        chk("arst_tc", 16'(TC), 16'h0);
        chk("arst_dout", 16'(DOUT), 16'h0);
        @(posedge CLK);
        #3 RSTL = 1'b1;
        repeat (4) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_reload_ctrl.md
Name: timer_reload_ctrl

Overview:
- Multi-bit programmable interval timer built around a loadable synchronous down-counter.
- Holds the CPU-visible reload, prescale and control registers, and generates the load and decrement timing.
- Detects terminal count, reloads or stops, and raises a latched interrupt toward the interrupt controller.
- Also provides a tear-free byte-wide readback of the live count.

Parameters:
- WIDTH, 16, counter and reload register width; fixed as two bytes (low, high).
- PRESCALE_W, 8, prescaler width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RSTL  in  1  asynchronous active-low reset.
- WR  in  1  register write strobe, single cycle.
- RD  in  1  register read strobe, single cycle.
- ADDR  in  2  register select: 0 count/reload low, 1 count/reload high, 2 prescale, 3 control.
- DIN  in  8  write data.
- DOUT  out  8  read data, registered.
- CNT  out  WIDTH  live counter value.
- TC  out  1  terminal-count pulse, one cycle.
- INT  out  1  latched interrupt request.
- IACK  in  1  interrupt acknowledge.

Behaviour:
- Reset (async, RSTL=0): reload=0, counter=0, prescale reg=0, prescaler=0, control=0, snapshot=0, DOUT=0, TC=0, INT=0.
  - Reset mid-count aborts immediately with no TC and no INT.
- Control register bits:
  - bit0 RUN.
  - bit1 ONESHOT.
  - bit2 IEN.
  - bits7..3 read as 0.
- Writes:
  - ADDR0 writes reload[7:0] only.
  - ADDR1 writes reload[15:8] and also loads counter <= {DIN, reload[7:0]} and prescaler <= prescale reg, effective at that edge. The load overrides any same-cycle tick or decrement, and no TC is generated for that cycle.
  - ADDR2 writes the prescale reg only; it takes effect at the next prescaler reload.
  - ADDR3 writes control. A RUN 0->1 transition also sets prescaler <= prescale reg.
- Prescaler, while RUN=1:
  - If prescaler==0: tick=1, prescaler <= prescale reg.
  - Else: prescaler decrements.
  - Prescale reg=N gives one tick every N+1 clocks; N=0 gives a tick every clock.
- Counter, on tick:
  - If counter!=0: counter decrements.
  - If counter==0: this is terminal count. TC=1 on the next cycle (registered, one cycle wide). counter <= reload. If ONESHOT=1, RUN is cleared at the same edge.
  - Reload=0 in periodic mode gives a TC on every tick.
- RUN=0 freezes both prescaler and counter; they resume from the frozen values when RUN returns to 1 (apart from the prescaler restart on a 0->1 write).
- INT:
  - Set at the same edge TC is registered, if IEN=1.
  - Cleared by IACK.
  - Simultaneous set and IACK: set wins, INT stays 1.
  - Clearing IEN does not clear a pending INT.
- Reads (DOUT valid the cycle after RD; held until the next RD):
  - ADDR0 returns counter[7:0] and, at the same edge, snapshot <= counter[15:8].
  - ADDR1 returns the snapshot, not the live high byte.
  - ADDR2 returns the prescale reg.
  - ADDR3 returns control, including a RUN bit already cleared by one-shot.
- Simultaneous RD and WR: the write occurs and the read returns pre-write values.
- CNT is combinationally the counter register, 0 after reset.

Test Plan:
- Reset then read all registers -> DOUT=0x00 for ADDR0..3; TC=0; INT=0.
- Write ADDR0=0x03, ADDR1=0x00, ADDR2=0x00, ADDR3=0x05 (RUN, IEN) -> CNT counts 3,2,1,0; TC pulses one cycle after the CNT=0 tick; CNT=3 again; INT=1 and stays 1 until IACK, then 0. Period is 4 clocks.
- Prescale=0x02, reload=0x0001, periodic -> TC every 6 clocks. Write ADDR3=0x00 mid-count -> CNT holds value, no TC.
- ONESHOT (ADDR3=0x03), reload=0x0002 -> exactly one TC; CNT=0x0002 afterwards. Reading ADDR3 -> 0x02, then no further TC for 20 clocks.
- Counter=0x12FF with a tick occurring between reads: RD ADDR0 -> 0xFF; counter decrements to 0x12FE; RD ADDR1 -> 0x12, not the live high byte. Also: IACK asserted in the same cycle as a new INT set -> INT remains 1.
- RSTL pulsed low for one cycle while CNT=0x0001 and INT=1 -> INT=0, TC=0, CNT=0 immediately, with no clock edge required.
